fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side controller for the team's synchronous FIFO.
- Takes a burst command (word count) and drains exactly that many words from the FIFO through its r_en/empty/data_out port.
- Presents the words on a valid/ready stream with a last flag.
- Absorbs the FIFO's 1-cycle registered read latency with an internal 3-entry skid buffer. Sustains one word per cycle with no combinational path from m_ready to fifo_r_en.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and stream data.
- LEN_WIDTH, 16, width of the burst length field; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid & cmd_ready.
- cmd_len  in  LEN_WIDTH  number of words to read.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_en  out  1  FIFO read enable.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after a fifo_r_en that was issued while not empty.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  marks final word of the burst.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State IDLE, counters cleared, buffer emptied.
- Reset mid-burst: abandons the burst. A FIFO read in flight is lost; no done pulse.
- States:
  - IDLE: cmd_ready=1. On accept with cmd_len>0, latch issue_left=rcv_left=cmd_len and go to RUN. On accept with cmd_len==0, pulse done next cycle and stay IDLE.
  - RUN: cmd_ready=0. Go to IDLE the cycle after the handshake of the word with m_last=1; done pulses in that same cycle.
- fifo_r_en = RUN & issue_left!=0 & !fifo_empty & (occ + inflight < 3).
  - occ = registered buffer occupancy; inflight = registered fifo_r_en from the previous cycle.
  - Registered terms only.
  - fifo_r_en is never asserted while fifo_empty=1, because the FIFO's count updates on r_en regardless of its empty flag.
- issue_left decrements on each fifo_r_en.
- When inflight=1, fifo_data is written into the buffer tail.
- Skid buffer: 3 entries, FIFO-ordered. m_valid = occ!=0; m_data = head entry.
  - Pop on m_valid & m_ready.
  - Push and pop in the same cycle leave occ unchanged.
  - Push when occ==3 is impossible by the issue rule; bench asserts it.
- rcv_left decrements on each pop. m_last = m_valid & (rcv_left==1).
- m_valid/m_data hold stable while m_valid & !m_ready.
- Latency:
  - First fifo_r_en is 1 cycle after command accept, provided the FIFO is non-empty.
  - First m_valid is 2 cycles after that fifo_r_en.
  - Steady-state throughput is 1 word/cycle when the FIFO is non-empty and m_ready=1.
- FIFO going empty mid-burst: issue pauses and resumes when fifo_empty deasserts; no words are duplicated or lost.
- Counter arithmetic: unsigned LEN_WIDTH, never below 0.

Optional Feature:
- Macro: FIFO_BURST_READER_ABORT_EN.
- With the macro: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in RUN forces issue_left to 0 that cycle.
  - Words already in flight or buffered are still delivered. m_last marks the last of them.
  - done pulses with aborted=1.
  - If nothing is pending, done/aborted pulse the next cycle with no m_last.
  - aborted resets to 0.
- Without the macro: neither port exists; bursts always run to cmd_len.

Decomposition:
- Package fifo_burst_reader_pkg:
  - state enum {IDLE, RUN};
  - localparam SKID_DEPTH=3;
  - occupancy width localparam $clog2(SKID_DEPTH+1).
- Sub-module fifo_rd_skid_buf: 3-entry push/pop buffer with occ output, parameterised by DATA_WIDTH.

Test Plan:
- FIFO preloaded with 0x10..0x17, cmd_len=8, m_ready=1 → m_data 0x10..0x17 on 8 consecutive cycles. m_last on 0x17, done the following cycle, cmd_ready back to 1.
- cmd_len=0 → no fifo_r_en, done pulses once, cmd_ready stays 1.
- cmd_len=6, m_ready toggled 1,0,0,1,0,1… → m_data held stable during stalls. Buffer occ never exceeds 3; exactly 6 fifo_r_en issued, in order.
- FIFO holds 2 words, cmd_len=5, remaining 3 words written 10 cycles later → no fifo_r_en while fifo_empty=1. 5 words delivered in order, m_last on the 5th.
- rst_n dropped asynchronously mid-burst (3 of 8 delivered) → outputs reset immediately, cmd_ready=1, no done. New cmd_len=2 then completes normally.
- With FIFO_BURST_READER_ABORT_EN: cmd_len=20, abort after 4th fifo_r_en → all 4 issued words delivered, m_last on the 4th, done & aborted pulse together.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader: controller state
// encoding, skid buffer depth and the derived occupancy/pointer widths.
package fifo_burst_reader_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int SKID_DEPTH = 3;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W      = $clog2(SKID_DEPTH);

  // Advance a circular skid-buffer pointer, wrapping after the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(SKID_DEPTH - 1)) begin
      ptr_inc = PTR_W'(0);
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small FIFO-ordered skid buffer (SKID_DEPTH entries) that catches words
// returning from the FIFO's registered read port. The head entry and the
// occupancy are both straight register outputs.
module fifo_rd_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_r [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Qualify push/pop so the buffer can never overflow or underflow.
  always_comb begin
    push_ok_s = push && (occ_r != OCC_W'(SKID_DEPTH));
    pop_ok_s  = pop && (occ_r != OCC_W'(0));
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps occ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      occ_r    <= OCC_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Storage: cleared on reset so the stream data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign occ       = occ_r;
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO. Accepts a word count,
// drains exactly that many words and streams them out with a last flag.
// The FIFO's one-cycle read latency is absorbed by a 3-entry skid buffer and
// the read enable depends only on registered state plus fifo_empty, so there
// is no combinational path from m_ready to fifo_r_en.
// Optional build macro: FIFO_BURST_READER_ABORT_EN adds abort/aborted ports
// for cutting a burst short while still delivering words already fetched.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
`ifdef FIFO_BURST_READER_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  done
);

  state_e                state_r;
  state_e                state_s;
  logic [LEN_WIDTH-1:0]  issue_left_r;
  logic [LEN_WIDTH-1:0]  issue_left_s;
  logic [LEN_WIDTH-1:0]  rcv_left_r;
  logic [LEN_WIDTH-1:0]  rcv_left_s;
  logic                  inflight_r;
  logic                  done_r;
  logic                  done_s;
  logic                  rd_en_s;
  logic                  pop_s;
  logic                  m_valid_s;
  logic                  last_pop_s;
  logic                  abort_now_s;
  logic [OCC_W-1:0]      occ_s;
  logic [OCC_W:0]        pending_s;
  logic [OCC_W:0]        remain_s;
  logic [DATA_WIDTH-1:0] head_s;

`ifdef FIFO_BURST_READER_ABORT_EN
  assign abort_now_s = abort && (state_r == RUN);
`else
  assign abort_now_s = 1'b0;
`endif

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (fifo_data),
    .pop       (pop_s),
    .occ       (occ_s),
    .head_data (head_s)
  );

  // Issue qualification and pop/last decode from registered occupancy only.
  always_comb begin
    pending_s  = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_r};
    m_valid_s  = (occ_s != OCC_W'(0));
    pop_s      = m_valid_s && m_ready;
    rd_en_s    = (state_r == RUN) && (issue_left_r != LEN_WIDTH'(0)) &&
                 !fifo_empty && (pending_s < (OCC_W+1)'(SKID_DEPTH)) &&
                 !abort_now_s;
    remain_s   = pending_s - {{OCC_W{1'b0}}, pop_s};
    last_pop_s = pop_s && (rcv_left_r == LEN_WIDTH'(1));
  end

  // Next-state and counter update for the IDLE/RUN controller.
  always_comb begin
    state_s      = state_r;
    issue_left_s = issue_left_r;
    rcv_left_s   = rcv_left_r;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != LEN_WIDTH'(0)) begin
            state_s      = RUN;
            issue_left_s = cmd_len;
            rcv_left_s   = cmd_len;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_now_s) begin
          // Only words already fetched remain; they become the new burst tail.
          issue_left_s = LEN_WIDTH'(0);
          rcv_left_s   = LEN_WIDTH'(remain_s);
          if (remain_s == (OCC_W+1)'(0)) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          if (rd_en_s) begin
            issue_left_s = issue_left_r - LEN_WIDTH'(1);
          end else begin
            issue_left_s = issue_left_r;
          end
          if (pop_s && (rcv_left_r != LEN_WIDTH'(0))) begin
            rcv_left_s = rcv_left_r - LEN_WIDTH'(1);
          end else begin
            rcv_left_s = rcv_left_r;
          end
          if (last_pop_s) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
      end
      default: begin
        state_s      = IDLE;
        issue_left_s = LEN_WIDTH'(0);
        rcv_left_s   = LEN_WIDTH'(0);
      end
    endcase
  end

  // Controller state, counters, read-in-flight flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      issue_left_r <= LEN_WIDTH'(0);
      rcv_left_r   <= LEN_WIDTH'(0);
      inflight_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      issue_left_r <= issue_left_s;
      rcv_left_r   <= rcv_left_s;
      inflight_r   <= rd_en_s;
      done_r       <= done_s;
    end
  end

`ifdef FIFO_BURST_READER_ABORT_EN
  logic abort_seen_r;
  logic aborted_r;

  // Remember an abort within the burst and flag it alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_seen_r <= 1'b0;
      aborted_r    <= 1'b0;
    end else begin
      aborted_r <= done_s && (state_r == RUN) && (abort_seen_r || abort_now_s);
      if (state_r == IDLE) begin
        abort_seen_r <= 1'b0;
      end else if (abort_now_s) begin
        abort_seen_r <= 1'b1;
      end else begin
        abort_seen_r <= abort_seen_r;
      end
    end
  end

  assign aborted = aborted_r;
`endif

  assign cmd_ready = (state_r == IDLE);
  assign fifo_r_en = rd_en_s;
  assign m_valid   = m_valid_s;
  assign m_data    = head_s;
  assign m_last    = m_valid_s && (rcv_left_r == LEN_WIDTH'(1));
  assign done      = done_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural FIFO with registered
// read data, a burst-level reference model (expected word list, words left,
// issued/delivered counts) checked every cycle on the falling edge, and a
// few literal latency expectations.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          done;
`ifdef FIFO_BURST_READER_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
`ifdef FIFO_BURST_READER_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural FIFO with a registered data_out.
  logic [DW-1:0] fifo_mem [64];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  logic fifo_flush;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  int  left = 0, issued = 0, delivered = 0, done_cnt = 0, aborted_cnt = 0;
  int  first_ren = -1, first_mv = -1, last_cyc = -1, done_cyc = -1;
  bit  busy = 1'b0, done_due = 1'b0, nxt_done = 1'b0, aborted_due = 1'b0;
  bit  hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int  acc_cyc = 0;
  int  saved_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read port: pop on r_en when not empty, data valid next cycle.
  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_r_en && (rd_ptr != wr_ptr)) begin
      fifo_data <= fifo_mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Per-cycle compare of the DUT against the burst-level model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      left = 0; busy = 1'b0; done_due = 1'b0; aborted_due = 1'b0;
      hold_prev = 1'b0; issued = 0; delivered = 0;
    end else begin
      nxt_done = 1'b0;
      chk("done", done, done_due);
`ifdef FIFO_BURST_READER_ABORT_EN
      chk("aborted", aborted, done_due && aborted_due);
      if (aborted) aborted_cnt++;
`endif
      if (done) begin done_cnt++; done_cyc = cyc; end
      chk("cmd_ready", cmd_ready, !busy);
      if (fifo_r_en) begin
        chk("ren_while_empty", fifo_empty, 1'b0);
        issued++;
        if (first_ren < 0) first_ren = cyc;
      end
      chk("ren_only_in_burst", fifo_r_en && !busy, 1'b0);
      chk("push_into_full_buf", dut.u_skid.push && (dut.u_skid.occ == 2'd3), 1'b0);
      if (cmd_valid && cmd_ready) begin
        issued = 0; delivered = 0; first_ren = -1; first_mv = -1; aborted_due = 1'b0;
        if (cmd_len == 16'd0) nxt_done = 1'b1;
        else begin busy = 1'b1; left = cmd_len; end
      end
`ifdef FIFO_BURST_READER_ABORT_EN
      if (abort && busy) begin
        aborted_due = 1'b1;
        left = issued - delivered;
        if (left == 0) begin nxt_done = 1'b1; busy = 1'b0; end
      end
`endif
      if (m_valid) begin
        if (first_mv < 0) first_mv = cyc;
        if (exp_q.size() == 0) chk("m_valid_unexpected", m_valid, 1'b0);
        else begin
          chk("m_data", m_data, exp_q[0]);
          chk("m_last", m_last, left == 1);
        end
        if (hold_prev) chk("m_data_stable", m_data, prev_data);
        if (m_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          delivered++;
          if (left == 1) begin nxt_done = 1'b1; busy = 1'b0; last_cyc = cyc; end
          if (left > 0) left--;
        end
      end else begin
        chk("m_last_no_valid", m_last, 1'b0);
        if (hold_prev) chk("m_valid_held", m_valid, 1'b1);
      end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
      done_due  = nxt_done;
    end
  end

  task automatic load(input logic [DW-1:0] base, input int n);
    @(posedge clk); #2;
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 64] = base + DW'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic expect_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
  endtask

  task automatic issue(input int len);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = LW'(len);
    @(posedge clk); #1;
    acc_cyc = cyc; cmd_valid = 1'b0; cmd_len = '0;
  endtask

  task automatic wait_done(input int maxc, input bit toggle);
    int k = 0;
    int start = done_cnt;
    while (done_cnt == start && k < maxc) begin
      @(posedge clk); #1;
      if (toggle) m_ready = pat[k % 6];
      k++;
    end
    m_ready = 1'b1;
    chk("burst_done_pulses", done_cnt - start, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic flush_fifo();
    @(posedge clk); #1 fifo_flush = 1'b1;
    @(posedge clk); #1 fifo_flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_len = '0; m_ready = 1'b1;
    fifo_flush = 1'b0; fifo_data = '0;
`ifdef FIFO_BURST_READER_ABORT_EN
    abort = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fifo_r_en", fifo_r_en, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Full-rate burst of 8 with fixed latencies.
    load(32'h10, 8);
    expect_words(32'h10, 8);
    issue(8);
    wait_done(100, 1'b0);
    chk("t1_first_ren", first_ren, acc_cyc);
    chk("t1_first_mvalid", first_mv, acc_cyc + 2);
    chk("t1_last_word", last_cyc, acc_cyc + 9);
    chk("t1_done", done_cyc, acc_cyc + 10);
    chk("t1_issued", issued, 8);

    // Zero-length command.
    issue(0);
    wait_done(10, 1'b0);
    chk("t2_issued", issued, 0);
    chk("t2_delivered", delivered, 0);

    // Back-pressure pattern 1,0,0,1,0,1.
    load(32'h20, 6);
    expect_words(32'h20, 6);
    issue(6);
    wait_done(200, 1'b1);
    chk("t3_issued", issued, 6);
    chk("t3_delivered", delivered, 6);

    // FIFO runs dry mid-burst, refilled 10 cycles later.
    load(32'h60, 2);
    expect_words(32'h60, 5);
    issue(5);
    repeat (10) @(posedge clk);
    load(32'h62, 3);
    wait_done(100, 1'b0);
    chk("t4_issued", issued, 5);
    chk("t4_delivered", delivered, 5);

    // Asynchronous reset after 3 of 8 words.
    load(32'h30, 8);
    expect_words(32'h30, 8);
    issue(8);
    for (int k = 0; k < 50 && delivered < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("t5_delivered_before_rst", delivered, 3);
    saved_done = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_cmd_ready", cmd_ready, 1'b1);
    chk("t5_rst_m_valid", m_valid, 1'b0);
    chk("t5_rst_m_last", m_last, 1'b0);
    chk("t5_rst_fifo_r_en", fifo_r_en, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    flush_fifo();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("t5_no_done_after_rst", done_cnt, saved_done);
    load(32'h40, 2);
    expect_words(32'h40, 2);
    issue(2);
    wait_done(50, 1'b0);
    chk("t5_new_delivered", delivered, 2);

`ifdef FIFO_BURST_READER_ABORT_EN
    // Abort after the 4th read; the four fetched words still drain.
    saved_done = aborted_cnt;
    load(32'h50, 20);
    expect_words(32'h50, 20);
    issue(20);
    for (int k = 0; k < 50 && issued < 4; k++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(50, 1'b0);
    chk("t6_issued", issued, 4);
    chk("t6_delivered", delivered, 4);
    chk("t6_aborted_pulses", aborted_cnt - saved_done, 1);
    exp_q.delete();
    flush_fifo();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
